// File: rtl/dmem_responder_pkg.sv
// Shared types for the CPU data-port responder: access sizes, FSM states
// and the byte-strobe width.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } MemSize;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_WAIT,
        RS_RESP
    } RespState;

    localparam int STRB_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU data-memory initiator (master)
// and the memory-side responder (slave).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    MemSize      req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_responder_sram.sv
// Word-organised SRAM: one synchronous read port and one byte-strobed
// write port.
module sram_bank
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [AW-1:0]     waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset branch so it maps onto an SRAM macro;
    // contents are undefined until software writes them.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a fixed response latency;
// stores commit on the acceptance edge, loads read the SRAM synchronously.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic       clk,
    input  logic       reset,
    dmem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    RespState          state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              cap_we, cap_err;
    logic              accept;
    logic              misaligned, out_of_range, req_err;
    logic [29:0]       word_idx;
    logic [STRB_W-1:0] wstrb;
    logic [31:0]       wdata_rep;
    logic [31:0]       sram_rdata;

    // Reset wins over a simultaneous request: nothing is accepted or written.
    assign accept   = bus.req_valid & bus.req_ready & ~reset;
    assign word_idx = bus.req_addr[31:2];

    assign out_of_range = {2'b00, word_idx} >= 32'(DEPTH_WORDS);
    assign req_err      = misaligned | out_of_range;

    always_comb begin
        misaligned = 1'b1;
        wstrb      = '0;
        wdata_rep  = '0;
        unique case (bus.req_size)
            MEM_B: begin
                misaligned = 1'b0;
                wstrb      = 4'b0001 << bus.req_addr[1:0];
                wdata_rep  = {4{bus.req_wdata[7:0]}};
            end
            MEM_H: begin
                misaligned = bus.req_addr[0];
                wstrb      = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{bus.req_wdata[15:0]}};
            end
            MEM_W: begin
                misaligned = |bus.req_addr[1:0];
                wstrb      = 4'b1111;
                wdata_rep  = bus.req_wdata;
            end
            default: ;
        endcase
    end

    sram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk   (clk),
        .we    (accept & bus.req_we & ~req_err),
        .wstrb (wstrb),
        .waddr (word_idx[AW-1:0]),
        .wdata (wdata_rep),
        .re    (accept & ~bus.req_we & ~req_err),
        .raddr (word_idx[AW-1:0]),
        .rdata (sram_rdata)
    );

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RS_IDLE;
            cnt     <= '0;
            cap_we  <= 1'b0;
            cap_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                cap_we  <= bus.req_we;
                cap_err <= req_err;
            end
        end
    end

    // NOTE: defaults first so no path through the case leaves a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            RS_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nx = RS_RESP;
                    end else begin
                        state_nx = RS_WAIT;
                        cnt_nx   = 4'(LATENCY - 1);
                    end
                end
            end
            RS_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt_nx == '0) state_nx = RS_RESP;
            end
            RS_RESP: begin
                if (bus.resp_ready) state_nx = RS_IDLE;
            end
            default: state_nx = RS_IDLE;
        endcase
    end

    // The SRAM read register is only reloaded on a load acceptance, so the
    // masked data stays stable for the whole response phase.
    always_comb begin
        bus.req_ready  = (state == RS_IDLE);
        bus.resp_valid = (state == RS_RESP);
        bus.resp_err   = bus.resp_valid & cap_err;
        bus.resp_rdata = (bus.resp_valid & ~cap_we & ~cap_err) ? sram_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-level memory model predicts
// each response; a monitor checks data, error, latency and handshake rules.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   hold  = 1'b0;
    int   cyc   = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    exp_t       exp_q [$];
    logic [7:0] mbytes [DEPTH*4];

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a flat byte array; an access touches size-many bytes
    // starting at the byte address, loads return the enclosing word.
    function automatic exp_t ref_access(logic we, MemSize sz, logic [31:0] addr, logic [31:0] wd);
        exp_t e;
        int   n;
        int   base;
        n = (sz == MEM_B) ? 1 : ((sz == MEM_H) ? 2 : 4);
        e.err   = ((addr % n) != 0) || ((addr / 4) >= DEPTH);
        e.rdata = '0;
        e.acc_cyc = 0;
        if (!e.err) begin
            base = int'(addr);
            if (we) begin
                for (int k = 0; k < n; k++) mbytes[base + k] = wd[8*k +: 8];
            end else begin
                base = (base / 4) * 4;
                for (int k = 0; k < 4; k++) e.rdata[8*k +: 8] = mbytes[base + k];
            end
        end
        return e;
    endfunction

    task automatic do_req(logic we, MemSize sz, logic [31:0] addr, logic [31:0] wd);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        while (bus.req_ready !== 1'b1) begin
            if (waited == 200) begin
                check("req_accept_timeout", {31'd0, bus.req_ready}, 32'd1);
                bus.req_valid = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        e = ref_access(we, sz, addr, wd);
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    // Response-side backpressure: random unless a test forces it low.
    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1 bus.resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every presented response against the queue head.
    initial begin
        bit   prev_valid = 1'b0;
        bit   after_hs   = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_valid = 1'b0;
                after_hs   = 1'b0;
            end else begin
                if (after_hs) begin
                    check("req_ready_after_resp", {31'd0, bus.req_ready}, 32'd1);
                    check("resp_valid_after_resp", {31'd0, bus.resp_valid}, 32'd0);
                    after_hs = 1'b0;
                end
                if (bus.resp_valid) begin
                    check("req_ready_during_resp", {31'd0, bus.req_ready}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
                    end else begin
                        e = exp_q[0];
                        if (!prev_valid) check("resp_latency", cyc, e.acc_cyc + LAT - 1);
                        check("resp_rdata", bus.resp_rdata, e.rdata);
                        check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
                        if (bus.resp_ready) begin
                            void'(exp_q.pop_front());
                            after_hs = 1'b1;
                        end
                    end
                end
                prev_valid = bus.resp_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d responses outstanding", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t;
        logic [31:0] addr;
        MemSize      sz;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = MEM_W;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("reset_resp_rdata", bus.resp_rdata, 32'd0);
        check("reset_resp_err", {31'd0, bus.resp_err}, 32'd0);
        reset = 1'b0;

        // Give every word a known value so any later load is predictable.
        for (int w = 0; w < DEPTH; w++) do_req(1'b1, MEM_W, 32'(w * 4), $urandom);
        drain();

        do_req(1'b1, MEM_W, 32'h10, 32'hDEAD_BEEF);
        do_req(1'b0, MEM_W, 32'h10, 32'h0);
        do_req(1'b1, MEM_W, 32'h20, 32'h0);
        do_req(1'b1, MEM_B, 32'h23, 32'h0000_00AB);
        do_req(1'b1, MEM_H, 32'h20, 32'h0000_1234);
        do_req(1'b0, MEM_W, 32'h20, 32'h0);
        do_req(1'b1, MEM_W, 32'h22, 32'hFFFF_FFFF);
        do_req(1'b0, MEM_W, 32'h20, 32'h0);
        do_req(1'b0, MEM_W, 32'(DEPTH * 4), 32'h0);
        drain();

        // Backpressure with a competing request held on the request side.
        hold = 1'b1;
        do_req(1'b0, MEM_W, 32'h10, 32'h0);
        t = 0;
        while (bus.resp_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        fork
            do_req(1'b1, MEM_W, 32'h14, 32'hCAFE_F00D);
        join_none
        repeat (5) @(negedge clk);
        hold = 1'b0;
        wait fork;
        drain();

        // Reset while the store's response is still counting down.
        do_req(1'b1, MEM_W, 32'h30, 32'h0000_0055);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("midwait_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("midwait_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        repeat (4) @(negedge clk);
        do_req(1'b0, MEM_W, 32'h30, 32'h0);
        drain();

        // Reset together with a store request: the store must not land.
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = MEM_W;
        bus.req_addr  = 32'h40;
        bus.req_wdata = ~{mbytes[67], mbytes[66], mbytes[65], mbytes[64]};
        @(negedge clk);
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        check("rstreq_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rstreq_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        do_req(1'b0, MEM_W, 32'h40, 32'h0);
        drain();

        for (int i = 0; i < 400; i++) begin
            sz = MemSize'($urandom_range(0, 2));
            t  = $urandom_range(0, 15);
            if (t == 0)      addr = 32'(DEPTH * 4 + $urandom_range(0, 63));
            else if (t == 1) addr = $urandom;
            else             addr = 32'($urandom_range(0, DEPTH * 4 - 1));
            if (t > 5) begin
                if (sz == MEM_H) addr[0] = 1'b0;
                if (sz == MEM_W) addr[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), sz, addr, $urandom);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
